// File: rtl/dm_store_if.sv
// Store-unit bus bundle: control-unit request side plus the word-wide data memory port.
// The slave modport is the store unit; the master modport is whatever drives it.
interface dm_store_if;
    logic        start;
    logic [1:0]  StoreSize;
    logic [31:0] Addr;
    logic [31:0] RegData;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [2:0]  fsm_state;

    // Handshake: start is a one-cycle request honoured only while busy=0; the
    // request completes with exactly one done pulse, qualified by misalign.
    modport slave (
        input  start, StoreSize, Addr, RegData, mem_rdata,
        output mem_addr, mem_wdata, mem_re, mem_we, busy, done, misalign, fsm_state
    );

    modport master (
        output start, StoreSize, Addr, RegData, mem_rdata,
        input  mem_addr, mem_wdata, mem_re, mem_we, busy, done, misalign, fsm_state
    );
endinterface

// File: rtl/dm_store_unit.sv
// MEM-phase store controller: word stores write directly, byte/half stores do a
// read-modify-write of the containing little-endian word.
module dm_store_unit (
    input  logic        clk,
    input  logic        Reset,
    dm_store_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] data_q;
    logic [31:0] wbuf;
    logic        mis_q;
    logic        req_bad;
    logic        accept;
    logic [31:0] merged;

    assign accept = (state_q == IDLE) && bus.start;

    // The verdict is taken on the operands being registered this edge, so it is
    // identical to checking addr_q/size_q and saves a cycle.
    always_comb begin
        req_bad = 1'b0;
        case (bus.StoreSize)
            SZ_HALF: req_bad = bus.Addr[0];
            SZ_WORD: req_bad = |bus.Addr[1:0];
            SZ_BYTE: req_bad = 1'b0;
            default: req_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            wbuf    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= bus.Addr;
                size_q <= bus.StoreSize;
                data_q <= bus.RegData;
                mis_q  <= req_bad;
            end
            if (state_q == MERGE) begin
                wbuf <= merged;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (req_bad)                        state_d = DONE;
                    else if (bus.StoreSize == SZ_WORD)  state_d = WRITE;
                    else                                state_d = READ;
                end
            end
            READ:    state_d = MERGE;
            MERGE:   state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane replacement into the word fetched during READ.
    always_comb begin
        merged = bus.mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else begin
            if (addr_q[1]) merged[31:16] = data_q[15:0];
            else           merged[15:0]  = data_q[15:0];
        end
    end

    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_re    = (state_q == READ);
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.mem_wdata = (state_q != WRITE) ? 32'h0 :
                           (size_q == SZ_WORD) ? data_q : wbuf;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.misalign  = (state_q == DONE) && mis_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_dm_store_unit.sv
// Bench for dm_store_unit: directed scenarios plus random stores against a word
// memory model, with a write scoreboard and a done/misalign scoreboard.
module tb_dm_store_unit;
    logic clk;
    logic Reset;
    dm_store_if bus ();

    dm_store_unit dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];
    logic        mis_q[$];
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word memory: write at the edge with mem_we, read data the cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end

    // Scoreboard / protocol monitor
    always @(negedge clk) begin
        logic viol;
        logic [63:0] e;
        viol = (bus.mem_re && bus.mem_we) ||
               ((bus.mem_re || bus.mem_we) && (!bus.busy || bus.done));
        check("strobe_rules", {63'd0, viol}, 64'd0);
        if (bus.mem_we) begin
            if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                check("write_addr", {32'd0, bus.mem_addr}, {32'd0, e[63:32]});
                check("write_data", {32'd0, bus.mem_wdata}, {32'd0, e[31:0]});
            end
        end
        if (bus.done) begin
            if (mis_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("done_misalign", {63'd0, bus.misalign}, {63'd0, mis_q.pop_front()});
        end
    end

    function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01) return a[0];
        if (sz == 2'b10) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] sz, input logic [31:0] a,
                                               input logic [31:0] d, input logic [31:0] old);
        logic [31:0] w;
        w = old;
        if (sz == 2'b10) w = d;
        else if (sz == 2'b01) begin
            if (a[1]) w = {d[15:0], old[15:0]};
            else      w = {old[31:16], d[15:0]};
        end else begin
            for (int k = 0; k < 4; k++)
                if (a[1:0] == k[1:0]) w[k*8 +: 8] = d[7:0];
        end
        return w;
    endfunction

    task automatic set_word(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    // Driver: issues one store and times its strobes relative to the accepting edge.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input bit glitch);
        logic bad;
        int lat, re_exp, we_exp, re_cyc, we_cyc, done_cyc;
        bad    = model_bad(sz, a);
        lat    = bad ? 1 : (sz == 2'b10 ? 2 : 4);
        re_exp = (!bad && sz != 2'b10) ? 1 : 0;
        we_exp = bad ? 0 : (sz == 2'b10 ? 1 : 3);
        if (!bad) begin
            ref_mem[a[7:2]] = model_word(sz, a, d, ref_mem[a[7:2]]);
            exp_q.push_back({a[31:2], 2'b00, ref_mem[a[7:2]]});
        end
        mis_q.push_back(bad);
        @(negedge clk);
        check("idle_before_start", {63'd0, bus.busy}, 64'd0);
        bus.start = 1'b1; bus.StoreSize = sz; bus.Addr = a; bus.RegData = d;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.Addr = $urandom; bus.RegData = $urandom;
        bus.StoreSize = 2'($urandom_range(0, 3));
        re_cyc = 0; we_cyc = 0; done_cyc = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus.mem_re && re_cyc == 0) re_cyc = n;
            if (bus.mem_we && we_cyc == 0) we_cyc = n;
            if (glitch && n == 1) begin
                bus.start = 1'b1; bus.StoreSize = 2'b10;
                bus.Addr = 32'h40; bus.RegData = 32'hFFFF_FFFF;
            end
            if (glitch && n == 2) bus.start = 1'b0;
            if (bus.done) begin
                done_cyc = n;
                break;
            end
        end
        check("done_cycle", 64'(done_cyc), 64'(lat));
        check("read_cycle", 64'(re_cyc), 64'(re_exp));
        check("write_cycle", 64'(we_cyc), 64'(we_exp));
    endtask

    initial begin
        logic [31:0] ra;
        for (int i = 0; i < 64; i++) set_word(i, 32'h0);
        bus.start = 1'b0; bus.StoreSize = 2'b00; bus.Addr = '0; bus.RegData = '0;
        Reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {bus.mem_addr, 27'd0, bus.mem_re, bus.mem_we, bus.busy, bus.done, bus.misalign},
              64'd0);
        check("reset_wdata", {32'd0, bus.mem_wdata}, 64'd0);
        Reset = 1'b1;

        run_store(2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
        check("word_mem", {32'd0, mem[4]}, {32'd0, 32'hDEAD_BEEF});

        set_word(8, 32'h1122_3344);
        run_store(2'b00, 32'h22, 32'h0000_00AA, 1'b0);
        check("byte_mem", {32'd0, mem[8]}, {32'd0, 32'h11AA_3344});
        set_word(8, 32'h1122_3344);
        run_store(2'b01, 32'h22, 32'h0000_BEEF, 1'b0);
        check("half_hi_mem", {32'd0, mem[8]}, {32'd0, 32'hBEEF_3344});
        set_word(8, 32'h1122_3344);
        run_store(2'b01, 32'h20, 32'h0000_BEEF, 1'b0);
        check("half_lo_mem", {32'd0, mem[8]}, {32'd0, 32'h1122_BEEF});

        run_store(2'b01, 32'h21, 32'h1234_5678, 1'b0);
        run_store(2'b10, 32'h22, 32'h1234_5678, 1'b0);
        run_store(2'b11, 32'h20, 32'h1234_5678, 1'b0);
        check("misalign_mem", {32'd0, mem[8]}, {32'd0, 32'h1122_BEEF});

        // Second start while busy is dropped; a start right after done is taken.
        set_word(8, 32'h1122_3344);
        set_word(16, 32'h0);
        run_store(2'b00, 32'h21, 32'h0000_0055, 1'b1);
        run_store(2'b10, 32'h44, 32'h1234_5678, 1'b0);
        check("glitch_byte_mem", {32'd0, mem[8]}, {32'd0, 32'h1122_5544});
        check("glitch_ignored", {32'd0, mem[16]}, 64'd0);
        check("b2b_word_mem", {32'd0, mem[17]}, {32'd0, 32'h1234_5678});

        // Reset during MERGE drops the request.
        @(negedge clk);
        bus.start = 1'b1; bus.StoreSize = 2'b00; bus.Addr = 32'h23; bus.RegData = 32'h77;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
        Reset = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs",
              {bus.mem_addr, 27'd0, bus.mem_re, bus.mem_we, bus.busy, bus.done, bus.misalign},
              64'd0);
        check("mid_reset_wdata", {32'd0, bus.mem_wdata}, 64'd0);
        Reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_no_write", {32'd0, mem[8]}, {32'd0, 32'h1122_5544});
        run_store(2'b10, 32'h10, 32'hDEAD_BEEF, 1'b0);
        check("post_reset_word", {32'd0, mem[4]}, {32'd0, 32'hDEAD_BEEF});

        for (int i = 0; i < 20; i++) begin
            ra = 32'($urandom_range(0, 255));
            run_store(2'($urandom_range(0, 3)), ra, $urandom, 1'b0);
        end
        for (int i = 0; i < 64; i++)
            check("final_mem", {32'd0, mem[i]}, {32'd0, ref_mem[i]});

        repeat (2) @(negedge clk);
        check("queues_drained", 64'(exp_q.size() + mis_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
